matrix_mac_unit: RTL and testbench

Sequential 3x3 signed matrix multiplier for the matrix extension of the RISC-V core. It consumes the A and B operand matrices that data memory unpacks on matrix-load instructions and computes R = A x B, one result element per cycle. It then presents the nine 32-bit results with a one-cycle `matrix_write` strobe, which the data memory uses to store them in its top result words.

---
 rtl/matrix_mac_unit_if.sv | 51 +++++
 rtl/matrix_mac_unit.sv | 154 +++++++++++++++
 tb/tb_matrix_mac_unit.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/matrix_mac_unit_if.sv
// Operand/result bundle for the 3x3 matrix multiplier.
// acc exists only when MATMUL_ACCUMULATE_EN is defined.
interface matrix_mac_unit_if #(
  parameter int ELEM_W = 13,
  parameter int ACC_W  = 32
);
  logic start;
`ifdef MATMUL_ACCUMULATE_EN
  logic acc;
`endif
  logic [ELEM_W-1:0] A_11, A_12, A_13;
  logic [ELEM_W-1:0] A_21, A_22, A_23;
  logic [ELEM_W-1:0] A_31, A_32, A_33;
  logic [ELEM_W-1:0] B_11, B_12, B_13;
  logic [ELEM_W-1:0] B_21, B_22, B_23;
  logic [ELEM_W-1:0] B_31, B_32, B_33;
  logic busy;
  logic matrix_write;
  logic done;
  logic [ACC_W-1:0] R_11, R_12, R_13;
  logic [ACC_W-1:0] R_21, R_22, R_23;
  logic [ACC_W-1:0] R_31, R_32, R_33;

  modport master (
`ifdef MATMUL_ACCUMULATE_EN
    output acc,
`endif
    output start,
    output A_11, A_12, A_13, A_21, A_22, A_23,
    output A_31, A_32, A_33,
    output B_11, B_12, B_13, B_21, B_22, B_23,
    output B_31, B_32, B_33,
    input  busy, matrix_write, done,
    input  R_11, R_12, R_13, R_21, R_22, R_23,
    input  R_31, R_32, R_33
  );

  modport slave (
`ifdef MATMUL_ACCUMULATE_EN
    input  acc,
`endif
    input  start,
    input  A_11, A_12, A_13, A_21, A_22, A_23,
    input  A_31, A_32, A_33,
    input  B_11, B_12, B_13, B_21, B_22, B_23,
    input  B_31, B_32, B_33,
    output busy, matrix_write, done,
    output R_11, R_12, R_13, R_21, R_22, R_23,
    output R_31, R_32, R_33
  );
endinterface

// File: rtl/matrix_mac_unit.sv
// Sequential 3x3 signed matrix multiply, one result element per cycle.
// Optional accumulate mode enabled by MATMUL_ACCUMULATE_EN.
module matrix_mac_unit #(
  parameter int ELEM_W = 13,
  parameter int ACC_W  = 32
) (
  input logic            clk,
  input logic            reset,
  matrix_mac_unit_if.slave m
);
  localparam int PW = 2 * ELEM_W;

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    WRITE
  } state_t;

  state_t state;
  logic [1:0] i;
  logic [1:0] j;
  logic busy;
  logic mw;
  logic done;

  logic signed [ELEM_W-1:0] a_q [3][3];
  logic signed [ELEM_W-1:0] b_q [3][3];
  logic [ACC_W-1:0] r [3][3];
  logic [ACC_W-1:0] dot;
  logic [ACC_W-1:0] nxt;
  logic take;

  function automatic logic [ACC_W-1:0] mul(
    input logic signed [ELEM_W-1:0] x,
    input logic signed [ELEM_W-1:0] y
  );
    logic signed [PW-1:0] xe;
    logic signed [PW-1:0] ye;
    logic signed [PW-1:0] p;
    xe = PW'(x);
    ye = PW'(y);
    p  = xe * ye;
    return ACC_W'(p);
  endfunction

  assign take = (state == IDLE) && m.start;

  always_ff @(posedge clk) begin
    if (take && !reset) begin
      a_q[0][0] <= m.A_11;
      a_q[0][1] <= m.A_12;
      a_q[0][2] <= m.A_13;
      a_q[1][0] <= m.A_21;
      a_q[1][1] <= m.A_22;
      a_q[1][2] <= m.A_23;
      a_q[2][0] <= m.A_31;
      a_q[2][1] <= m.A_32;
      a_q[2][2] <= m.A_33;
      b_q[0][0] <= m.B_11;
      b_q[0][1] <= m.B_12;
      b_q[0][2] <= m.B_13;
      b_q[1][0] <= m.B_21;
      b_q[1][1] <= m.B_22;
      b_q[1][2] <= m.B_23;
      b_q[2][0] <= m.B_31;
      b_q[2][1] <= m.B_32;
      b_q[2][2] <= m.B_33;
    end
  end

`ifdef MATMUL_ACCUMULATE_EN
  logic acc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= 1'b0;
    end else if (take) begin
      acc_q <= m.acc;
    end
  end

  assign nxt = acc_q ? r[i][j] + dot : dot;
`else
  assign nxt = dot;
`endif

  always_comb begin
    dot = mul(a_q[i][0], b_q[0][j])
        + mul(a_q[i][1], b_q[1][j])
        + mul(a_q[i][2], b_q[2][j]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      i     <= 2'd0;
      j     <= 2'd0;
      busy  <= 1'b0;
      mw    <= 1'b0;
      done  <= 1'b0;
      for (int x = 0; x < 3; x++) begin
        for (int y = 0; y < 3; y++) begin
          r[x][y] <= '0;
        end
      end
    end else begin
      mw   <= 1'b0;
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (m.start) begin
            state <= COMPUTE;
            i     <= 2'd0;
            j     <= 2'd0;
            busy  <= 1'b1;
          end
        end
        COMPUTE: begin
          r[i][j] <= nxt;
          if (i == 2'd2 && j == 2'd2) begin
            state <= WRITE;
            i     <= 2'd0;
            j     <= 2'd0;
            mw    <= 1'b1;
            done  <= 1'b1;
          end else if (j == 2'd2) begin
            i <= i + 2'd1;
            j <= 2'd0;
          end else begin
            j <= j + 2'd1;
          end
        end
        WRITE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign m.busy         = busy;
  assign m.matrix_write = mw;
  assign m.done         = done;
  assign m.R_11 = r[0][0];
  assign m.R_12 = r[0][1];
  assign m.R_13 = r[0][2];
  assign m.R_21 = r[1][0];
  assign m.R_22 = r[1][1];
  assign m.R_23 = r[1][2];
  assign m.R_31 = r[2][0];
  assign m.R_32 = r[2][1];
  assign m.R_33 = r[2][2];
endmodule

// File: tb/tb_matrix_mac_unit.sv
// Directed vector bench for matrix_mac_unit.
// Table-driven operations plus hand-written overlap/reset/accumulate cases.
module tb_matrix_mac_unit;
  logic clk;
  logic reset;

  matrix_mac_unit_if #(.ELEM_W(13), .ACC_W(32)) m ();

  matrix_mac_unit #(.ELEM_W(13), .ACC_W(32)) dut (
    .clk  (clk),
    .reset(reset),
    .m    (m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [12:0] a [9];
    logic [12:0] b [9];
    logic [31:0] r [9];
  } vec_t;

  int tests;
  int fails;
  vec_t tv [6];
  vec_t v12;
  vec_t vm1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] rd(input int k);
    case (k)
      0: return m.R_11;
      1: return m.R_12;
      2: return m.R_13;
      3: return m.R_21;
      4: return m.R_22;
      5: return m.R_23;
      6: return m.R_31;
      7: return m.R_32;
      default: return m.R_33;
    endcase
  endfunction

  function automatic vec_t uni(input string nm, input logic [12:0] av,
                               input logic [12:0] bv,
                               input logic [31:0] rv);
    vec_t t;
    t.name = nm;
    for (int k = 0; k < 9; k++) begin
      t.a[k] = av;
      t.b[k] = bv;
      t.r[k] = rv;
    end
    return t;
  endfunction

  task automatic set_ops(input vec_t t);
    m.A_11 = t.a[0]; m.A_12 = t.a[1]; m.A_13 = t.a[2];
    m.A_21 = t.a[3]; m.A_22 = t.a[4]; m.A_23 = t.a[5];
    m.A_31 = t.a[6]; m.A_32 = t.a[7]; m.A_33 = t.a[8];
    m.B_11 = t.b[0]; m.B_12 = t.b[1]; m.B_13 = t.b[2];
    m.B_21 = t.b[3]; m.B_22 = t.b[4]; m.B_23 = t.b[5];
    m.B_31 = t.b[6]; m.B_32 = t.b[7]; m.B_33 = t.b[8];
  endtask

  task automatic chk_r(input string nm, input vec_t t);
    for (int k = 0; k < 9; k++) begin
      chk($sformatf("%s R[%0d]", nm, k), rd(k), t.r[k]);
    end
  endtask

  task automatic do_op(input vec_t t, input bit accv);
    int lat;
    int bc;
    int mc;
    int dm;
    set_ops(t);
    @(negedge clk);
    m.start = 1'b1;
`ifdef MATMUL_ACCUMULATE_EN
    m.acc = accv;
`endif
    @(posedge clk);
    #1;
    m.start = 1'b0;
    lat = -1;
    bc = 0;
    mc = 0;
    dm = 0;
    for (int c = 0; c < 15; c++) begin
      if (c == 1) set_ops(uni("junk", 13'h0AB, 13'h155, 0));
      if (m.busy) bc++;
      if (m.done !== m.matrix_write) dm++;
      if (m.matrix_write) begin
        mc++;
        if (lat < 0) begin
          lat = c;
          chk_r(t.name, t);
        end
      end
      @(posedge clk);
      #1;
    end
    chk({t.name, " latency"}, lat, 9);
    chk({t.name, " busy cycles"}, bc, 10);
    chk({t.name, " strobes"}, mc, 1);
    chk({t.name, " done vs strobe"}, dm, 0);
    chk_r({t.name, " held"}, t);
  endtask

  initial begin
    int mc;
    vec_t acc2;
    vec_t zero;
    tests = 0;
    fails = 0;
    reset = 1'b1;
    m.start = 1'b0;
`ifdef MATMUL_ACCUMULATE_EN
    m.acc = 1'b0;
`endif
    zero = uni("zero", 13'd0, 13'd0, 32'd0);
    set_ops(zero);

    tv[0].name = "identity";
    for (int k = 0; k < 9; k++) begin
      tv[0].a[k] = (k % 4 == 0) ? 13'd1 : 13'd0;
      tv[0].b[k] = 13'(k + 1);
      tv[0].r[k] = 32'(k + 1);
    end
    tv[1] = uni("ones_twos", 13'd1, 13'd2, 32'd6);
    tv[2] = uni("minus1", 13'h1FFF, 13'h1FFF, 32'd3);
    tv[3] = uni("max_pos", 13'd4095, 13'd4095, 32'd50307075);
    tv[4] = uni("max_neg", 13'h1000, 13'h1000, 32'd50331648);
    tv[5].name = "a11_neg";
    for (int k = 0; k < 9; k++) begin
      tv[5].a[k] = (k == 0) ? 13'h1FFF : 13'd0;
      tv[5].b[k] = (k % 4 == 0) ? 13'd1 : 13'd0;
      tv[5].r[k] = (k == 0) ? 32'hFFFFFFFF : 32'd0;
    end
    v12 = tv[1];
    vm1 = tv[2];

    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", m.busy, 0);
    chk("reset strobe", m.matrix_write, 0);
    chk("reset done", m.done, 0);
    chk_r("reset", zero);
    reset = 1'b0;

    for (int v = 0; v < 6; v++) begin
      do_op(tv[v], 1'b0);
    end

    // Second start three edges into the first operation must be ignored.
    set_ops(v12);
    @(negedge clk);
    m.start = 1'b1;
    @(posedge clk);
    #1;
    m.start = 1'b0;
    mc = 0;
    for (int c = 0; c < 15; c++) begin
      if (c == 2) begin
        set_ops(vm1);
        m.start = 1'b1;
      end else begin
        m.start = 1'b0;
      end
      if (m.matrix_write) mc++;
      @(posedge clk);
      #1;
    end
    chk("overlap strobes", mc, 1);
    chk_r("overlap", v12);
    do_op(vm1, 1'b0);

    // Reset five edges after the start abandons the operation.
    set_ops(tv[3]);
    @(negedge clk);
    m.start = 1'b1;
    @(posedge clk);
    #1;
    m.start = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("midreset busy", m.busy, 0);
    chk("midreset strobe", m.matrix_write, 0);
    chk_r("midreset", zero);
    mc = 0;
    for (int c = 0; c < 12; c++) begin
      if (m.matrix_write || m.busy) mc++;
      @(posedge clk);
      #1;
    end
    chk("midreset no activity", mc, 0);

    do_op(v12, 1'b0);
`ifdef MATMUL_ACCUMULATE_EN
    acc2 = uni("accumulate", 13'd1, 13'd2, 32'd12);
`else
    acc2 = uni("accumulate", 13'd1, 13'd2, 32'd6);
`endif
    do_op(acc2, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
